// File: rtl/mbist_ser_pkg.sv
// ============================================================================
// mbist_ser_pkg : shared types and constants for the MBIST serial slave.
// Rev 1.0
// ============================================================================
`default_nettype none

package mbist_ser_pkg;

  localparam int FRAME_LEN = 32;
  localparam int CNT_W     = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mbist_ser_slv.sv
// ============================================================================
// mbist_ser_slv : 32-bit serial config/status slave, LSB first.
// Rev 1.0
// ============================================================================
`default_nettype none

module mbist_ser_slv #(
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift,
  input  logic        sdi,
  output logic        sdo,
  input  logic        wr_mode,
  input  logic [31:0] cap_data,
  output logic [31:0] cfg_data,
  output logic        cfg_upd,
  output logic        frame_err,
  input  logic        err_clr,
  output logic        busy
);

  import mbist_ser_pkg::*;

  state_t           state;
  logic [31:0]      shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             wr_lat;

  logic frame_end;
  logic len_ok;

  assign frame_end = (state == SHIFT) && !shift;
  assign len_ok    = (bit_cnt == CNT_W'(FRAME_LEN));
  assign sdo       = shift_reg[0];
  assign busy      = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= 32'h0;
      bit_cnt   <= '0;
      wr_lat    <= 1'b0;
      cfg_data  <= RESET_VAL;
      cfg_upd   <= 1'b0;
    end else begin
      cfg_upd <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (shift) begin
            shift_reg <= {sdi, shift_reg[31:1]};
            bit_cnt   <= CNT_W'(1);
            wr_lat    <= wr_mode;
            state     <= SHIFT;
          end else begin
            shift_reg <= cap_data;
            state     <= IDLE;
          end
        end
        SHIFT: begin
          if (shift) begin
            shift_reg <= {sdi, shift_reg[31:1]};
            // Saturate so an overlong frame can never wrap back to a legal length.
            if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            bit_cnt <= '0;
            state   <= DONE;
            if (len_ok && wr_lat) begin
              cfg_data <= shift_reg;
              cfg_upd  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A length error in the same cycle as err_clr must win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (frame_end && !len_ok) begin
      frame_err <= 1'b1;
    end else if (err_clr) begin
      frame_err <= 1'b0;
    end
  end

endmodule

`default_nettype wire
